// File: rtl/eig_pkg.sv
// Shared state/error encodings and default limits for the eigenvalue watchdog sequencer.
package eig_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CSTART,
        CORE,
        OSTART,
        OUT,
        ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CORE_TO = 2'b01,
        ERR_OL_TO   = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_code_t;

    localparam int unsigned DEF_TIMEOUT_W    = 16;
    localparam int unsigned DEF_CORE_TIMEOUT = 4000;
    localparam int unsigned DEF_OL_TIMEOUT   = 64;
    localparam int unsigned DEF_RUN_CNT_W    = 8;

    // A parameter-ready pulse in any of these states is an overrun.
    function automatic logic run_in_flight(input seq_state_t s);
        return (s == CSTART) || (s == CORE) || (s == OSTART) || (s == OUT);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase supervisor: counts phase cycles, remembers whether busy was seen,
// and flags busy-fall completion or timeout for the sequencer.
module phase_timer #(
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 i_clear,
    input  logic                 i_run,
    input  logic                 i_busy,
    input  logic [TIMEOUT_W-1:0] i_limit,
    output logic                 o_complete,
    output logic                 o_timeout
);

    logic [TIMEOUT_W-1:0] r_count;
    logic                 r_seen;
    logic [TIMEOUT_W-1:0] w_count_inc;

    assign w_count_inc = r_count + 1'b1;

    // Completion wins over a timeout landing on the same cycle.
    assign o_complete = i_run && r_seen && !i_busy;
    assign o_timeout  = i_run && !o_complete && (w_count_inc >= i_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_seen  <= 1'b0;
        end else if (ena) begin
            if (i_clear) begin
                // Busy already high during the start cycle still counts as seen.
                r_count <= '0;
                r_seen  <= i_busy;
            end else if (i_run) begin
                r_count <= w_count_inc;
                if (i_busy) begin
                    r_seen <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/eig_sequencer.sv
// Top-level run controller: parameter capture -> eigen core -> output loader,
// with per-phase timeout supervision and sticky error reporting.
module eig_sequencer
    import eig_pkg::*;
#(
    parameter int unsigned TIMEOUT_W    = DEF_TIMEOUT_W,
    parameter int unsigned CORE_TIMEOUT = DEF_CORE_TIMEOUT,
    parameter int unsigned OL_TIMEOUT   = DEF_OL_TIMEOUT,
    parameter int unsigned RUN_CNT_W    = DEF_RUN_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 params_rdy,
    input  logic                 core_busy,
    input  logic                 ol_busy,
    input  logic                 clr_err,
    output logic                 core_start,
    output logic                 ol_start,
    output logic                 pl_hold,
    output logic                 seq_busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [RUN_CNT_W-1:0] run_cnt
);

    localparam logic [TIMEOUT_W-1:0] CORE_LIMIT = TIMEOUT_W'(CORE_TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] OL_LIMIT   = TIMEOUT_W'(OL_TIMEOUT);

    seq_state_t            r_state;
    seq_state_t            w_state_next;
    err_code_t             r_err_code;
    err_code_t             w_err_code_next;
    logic                  r_core_start;
    logic                  r_ol_start;
    logic                  r_done;
    logic                  r_err;
    logic                  r_active;
    logic [RUN_CNT_W-1:0]  r_run_cnt;

    logic                  w_run_done;
    logic                  w_core_phase;
    logic                  w_timer_clear;
    logic                  w_timer_run;
    logic                  w_busy_sel;
    logic [TIMEOUT_W-1:0]  w_limit;
    logic                  w_phase_complete;
    logic                  w_phase_timeout;

    // One timer serves both phases; busy and limit follow the current phase.
    assign w_core_phase  = (r_state == CSTART) || (r_state == CORE);
    assign w_timer_clear = (r_state == CSTART) || (r_state == OSTART);
    assign w_timer_run   = (r_state == CORE) || (r_state == OUT);
    assign w_busy_sel    = w_core_phase ? core_busy : ol_busy;
    assign w_limit       = w_core_phase ? CORE_LIMIT : OL_LIMIT;

    phase_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .i_clear    (w_timer_clear),
        .i_run      (w_timer_run),
        .i_busy     (w_busy_sel),
        .i_limit    (w_limit),
        .o_complete (w_phase_complete),
        .o_timeout  (w_phase_timeout)
    );

    always_comb begin
        w_state_next    = r_state;
        w_err_code_next = r_err_code;
        w_run_done      = 1'b0;

        case (r_state)
            IDLE: begin
                if (params_rdy) begin
                    w_state_next = CSTART;
                end
            end
            CSTART: w_state_next = CORE;
            CORE: begin
                if (w_phase_complete) begin
                    w_state_next = OSTART;
                end else if (w_phase_timeout) begin
                    w_state_next    = ERR;
                    w_err_code_next = ERR_CORE_TO;
                end
            end
            OSTART: w_state_next = OUT;
            OUT: begin
                if (w_phase_complete) begin
                    w_state_next = IDLE;
                    w_run_done   = 1'b1;
                end else if (w_phase_timeout) begin
                    w_state_next    = ERR;
                    w_err_code_next = ERR_OL_TO;
                end
            end
            ERR: begin
                // A params pulse arriving with clr_err is deliberately dropped.
                if (clr_err) begin
                    w_state_next    = IDLE;
                    w_err_code_next = ERR_NONE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Overrun overrides any same-cycle completion or timeout.
        if (params_rdy && run_in_flight(r_state)) begin
            w_state_next    = ERR;
            w_err_code_next = ERR_OVERRUN;
            w_run_done      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_err_code   <= ERR_NONE;
            r_core_start <= 1'b0;
            r_ol_start   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_active     <= 1'b0;
            r_run_cnt    <= '0;
        end else if (ena) begin
            r_state      <= w_state_next;
            r_err_code   <= w_err_code_next;
            r_core_start <= (w_state_next == CSTART);
            r_ol_start   <= (w_state_next == OSTART);
            r_done       <= w_run_done;
            r_err        <= (w_state_next == ERR);
            r_active     <= (w_state_next != IDLE);
            r_run_cnt    <= r_run_cnt + RUN_CNT_W'(w_run_done);
        end else begin
            // Frozen: levels hold, pulses die and are never replayed.
            r_core_start <= 1'b0;
            r_ol_start   <= 1'b0;
            r_done       <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        assert (longint'(CORE_TIMEOUT) < (64'sd1 <<< TIMEOUT_W));
        assert (longint'(OL_TIMEOUT) < (64'sd1 <<< TIMEOUT_W));
    end

    assign core_start = r_core_start;
    assign ol_start   = r_ol_start;
    assign pl_hold    = r_active;
    assign seq_busy   = r_active;
    assign done       = r_done;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign run_cnt    = r_run_cnt;

endmodule

// File: tb/tb_eig_sequencer.sv
// Directed bench for eig_sequencer: nominal run, timeouts, overrun, freeze, reset and wrap.
module tb_eig_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       params_rdy;
    logic       core_busy;
    logic       ol_busy;
    logic       clr_err;
    logic       core_start;
    logic       ol_start;
    logic       pl_hold;
    logic       seq_busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [1:0] run_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    eig_sequencer #(
        .TIMEOUT_W    (16),
        .CORE_TIMEOUT (16),
        .OL_TIMEOUT   (64),
        .RUN_CNT_W    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .params_rdy (params_rdy),
        .core_busy  (core_busy),
        .ol_busy    (ol_busy),
        .clr_err    (clr_err),
        .core_start (core_start),
        .ol_start   (ol_start),
        .pl_hold    (pl_hold),
        .seq_busy   (seq_busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .run_cnt    (run_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; params_rdy = 1'b0;
        core_busy = 1'b0; ol_busy = 1'b0; clr_err = 1'b0;
        tick();
        tick();
        chk("rst_core_start", 0, int'(core_start), 0);
        chk("rst_ol_start",   0, int'(ol_start), 0);
        chk("rst_pl_hold",    0, int'(pl_hold), 0);
        chk("rst_seq_busy",   0, int'(seq_busy), 0);
        chk("rst_done",       0, int'(done), 0);
        chk("rst_err",        0, int'(err), 0);
        chk("rst_err_code",   0, int'(err_code), 0);
        chk("rst_run_cnt",    0, int'(run_cnt), 0);
        rst = 1'b0;
        $display("[TB] reset: outputs cleared");

        // Nominal run
        for (int n = 0; n <= 35; n++) begin
            params_rdy = (n == 10);
            core_busy  = (n >= 12 && n <= 20);
            ol_busy    = (n >= 23 && n <= 30);
            chk("nom_core_start", n, int'(core_start), int'(n == 11));
            chk("nom_ol_start",   n, int'(ol_start), int'(n == 22));
            chk("nom_done",       n, int'(done), int'(n == 32));
            chk("nom_pl_hold",    n, int'(pl_hold), int'(n >= 11 && n <= 31));
            chk("nom_err",        n, int'(err), 0);
            tick();
        end
        chk("nom_run_cnt", 36, int'(run_cnt), 1);
        $display("[TB] nominal run: run_cnt=%0d", run_cnt);

        // Core timeout: busy never rises
        for (int n = 0; n <= 25; n++) begin
            params_rdy = (n == 0);
            core_busy  = 1'b0;
            ol_busy    = 1'b0;
            clr_err    = (n == 22);
            chk("cto_core_start", n, int'(core_start), int'(n == 1));
            chk("cto_ol_start",   n, int'(ol_start), 0);
            chk("cto_err",        n, int'(err), int'(n >= 18 && n <= 22));
            chk("cto_err_code",   n, int'(err_code), (n >= 18 && n <= 22) ? 1 : 0);
            chk("cto_seq_busy",   n, int'(seq_busy), int'(n >= 1 && n <= 22));
            tick();
        end
        clr_err = 1'b0;
        chk("cto_run_cnt", 26, int'(run_cnt), 1);
        $display("[TB] core timeout: err raised and cleared, run_cnt=%0d", run_cnt);

        // Overrun coinciding with core completion, then clr_err + params together
        for (int n = 0; n <= 18; n++) begin
            params_rdy = (n == 0) || (n == 5) || (n == 15);
            clr_err    = (n == 15);
            core_busy  = (n >= 2 && n <= 4);
            ol_busy    = 1'b0;
            chk("ovr_core_start", n, int'(core_start), int'(n == 1));
            chk("ovr_ol_start",   n, int'(ol_start), 0);
            chk("ovr_done",       n, int'(done), 0);
            chk("ovr_err",        n, int'(err), int'(n >= 6 && n <= 15));
            chk("ovr_err_code",   n, int'(err_code), (n >= 6 && n <= 15) ? 3 : 0);
            chk("ovr_seq_busy",   n, int'(seq_busy), int'(n >= 1 && n <= 15));
            tick();
        end
        params_rdy = 1'b0; clr_err = 1'b0;
        chk("ovr_run_cnt", 19, int'(run_cnt), 1);
        $display("[TB] overrun: err_code 11 then cleared, params dropped");

        // Enable freeze in CORE outlasting the timeout limit
        for (int n = 0; n <= 70; n++) begin
            ena        = !(n >= 5 && n <= 54);
            params_rdy = (n == 0);
            core_busy  = (n >= 55 && n <= 58);
            ol_busy    = (n >= 61 && n <= 62);
            chk("frz_err",        n, int'(err), 0);
            chk("frz_core_start", n, int'(core_start), int'(n == 1));
            chk("frz_ol_start",   n, int'(ol_start), int'(n == 60));
            chk("frz_done",       n, int'(done), int'(n == 64));
            chk("frz_seq_busy",   n, int'(seq_busy), int'(n >= 1 && n <= 63));
            tick();
        end
        ena = 1'b1;
        chk("frz_run_cnt", 71, int'(run_cnt), 2);
        $display("[TB] ena freeze: no timeout, run_cnt=%0d", run_cnt);

        // Reset during OUT, then a clean run
        for (int n = 0; n <= 20; n++) begin
            rst        = (n == 8);
            params_rdy = (n == 0) || (n == 11);
            core_busy  = (n >= 2 && n <= 3) || (n == 13);
            ol_busy    = (n >= 6 && n <= 10) || (n == 16);
            chk("rmo_core_start", n, int'(core_start), int'(n == 1 || n == 12));
            chk("rmo_ol_start",   n, int'(ol_start), int'(n == 5 || n == 15));
            chk("rmo_done",       n, int'(done), int'(n == 18));
            chk("rmo_pl_hold",    n, int'(pl_hold),
                int'((n >= 1 && n <= 8) || (n >= 12 && n <= 17)));
            chk("rmo_err",        n, int'(err), 0);
            chk("rmo_err_code",   n, int'(err_code), 0);
            chk("rmo_run_cnt",    n, int'(run_cnt), (n <= 8) ? 2 : ((n >= 18) ? 1 : 0));
            tick();
        end
        rst = 1'b0;
        $display("[TB] reset mid-OUT: clean restart, run_cnt=%0d", run_cnt);

        // Five back-to-back minimal runs across the 2-bit counter wrap
        for (int n = 0; n <= 36; n++) begin
            int m;
            m = (n >= 1) ? ((n - 1) % 7) : -1;
            rst        = (n == 0);
            params_rdy = (m == 0) && (n <= 29);
            core_busy  = (m == 2);
            ol_busy    = (m == 5);
            if (n >= 1) begin
                chk("wrp_core_start", n, int'(core_start), int'(m == 1));
                chk("wrp_ol_start",   n, int'(ol_start), int'(m == 4));
                chk("wrp_done",       n, int'(done), int'(n >= 8 && m == 0));
                chk("wrp_run_cnt",    n, int'(run_cnt), ((n - 1) / 7) % 4);
            end
            if (n >= 8 && m == 0) begin
                $display("[TB] wrap run done at cyc %0d: run_cnt=%0d", n, run_cnt);
            end
            tick();
        end
        params_rdy = 1'b0; core_busy = 1'b0; ol_busy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
